// File: rtl/csnc_xor_combiner.sv
// CSNC encoder combiner: XOR-folds NUM_SRC rotated source words into one coded word
// and hands it to the packet assembler over valid/ready, flagging frame misalignment.
module csnc_xor_combiner #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned CntW = $clog2(NUM_SRC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NUM_SRC - 1);

  logic [WIDTH-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_done;
  logic             w_cnt_full;
  logic             w_close;
  logic [WIDTH-1:0] w_acc_next;

  // Only combinational path in the block: out_ready -> in_ready.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_done = r_out_valid && out_ready;
  assign w_cnt_full = (r_cnt == CntMax);
  assign w_close    = w_accept && (w_cnt_full || in_last);
  // r_acc is zero at the start of every frame, so the first beat loads in_data directly.
  assign w_acc_next = r_acc ^ in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_close) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc_next;
      r_out_err   <= (in_last != w_cnt_full);
    end else begin
      if (w_out_done) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_csnc_xor_combiner.sv
// Bench for csnc_xor_combiner: three instances (NUM_SRC = 2, 3, 1) checked every cycle
// against a frame-level reference model, plus directed scenarios and a random soak.
module tb_csnc_xor_combiner;

  localparam int NumInst = 3;
  localparam int NsTab[NumInst] = '{2, 3, 1};

  logic       clk;
  logic       rst_n;
  logic       iv[NumInst];
  logic       ir[NumInst];
  logic [3:0] id[NumInst];
  logic       il[NumInst];
  logic       ov[NumInst];
  logic       ordy[NumInst];
  logic [3:0] od[NumInst];
  logic       oe[NumInst];

  int n_checks;
  int n_errors;
  bit mon_en;

  // Reference model: frame contents and the single-word output slot.
  logic [3:0] m_acc[NumInst];
  int         m_cnt[NumInst];
  logic       m_ov[NumInst];
  logic [3:0] m_od[NumInst];
  logic       m_oe[NumInst];

  csnc_xor_combiner #(.WIDTH(4), .NUM_SRC(2)) u_dut_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_err(oe[0])
  );
  csnc_xor_combiner #(.WIDTH(4), .NUM_SRC(3)) u_dut_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_err(oe[1])
  );
  csnc_xor_combiner #(.WIDTH(4), .NUM_SRC(1)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_err(oe[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int k, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[inst %0d] got %0h expected %0h at %0t", tag, k, got, exp, $time);
    end
  endtask

  // Compare at negedge, then advance the model to the state after the coming posedge.
  always @(negedge clk) begin
    for (int k = 0; k < NumInst; k++) begin
      if (!rst_n) begin
        m_acc[k] = '0;
        m_cnt[k] = 0;
        m_ov[k]  = 1'b0;
        m_od[k]  = '0;
        m_oe[k]  = 1'b0;
        if (mon_en) check_eq("rst_out_valid", k, 32'(ov[k]), 32'd0);
      end else if (mon_en) begin
        logic       rdy;
        logic       acc;
        logic [3:0] a;
        rdy = !m_ov[k] || ordy[k];
        check_eq("in_ready", k, 32'(ir[k]), 32'(rdy));
        check_eq("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
        if (m_ov[k]) begin
          check_eq("out_data", k, 32'(od[k]), 32'(m_od[k]));
          check_eq("out_err", k, 32'(oe[k]), 32'(m_oe[k]));
        end
        acc = iv[k] && rdy;
        if (m_ov[k] && ordy[k]) m_ov[k] = 1'b0;
        if (acc) begin
          a = m_acc[k] ^ id[k];
          if ((m_cnt[k] + 1 == NsTab[k]) || il[k]) begin
            m_ov[k]  = 1'b1;
            m_od[k]  = a;
            m_oe[k]  = (m_cnt[k] + 1 != NsTab[k]) || !il[k];
            m_acc[k] = '0;
            m_cnt[k] = 0;
          end else begin
            m_acc[k] = a;
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  end

  // Present one beat for one clock; starts and ends just after a rising edge.
  task automatic drive(input int k, input logic v, input logic [3:0] d, input logic l,
                       input logic r);
    iv[k]   = v;
    id[k]   = d;
    il[k]   = l;
    ordy[k] = r;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  initial begin
    logic [3:0] bb[6];
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    for (int k = 0; k < NumInst; k++) begin
      iv[k] = 1'b0; id[k] = '0; il[k] = 1'b0; ordy[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NumInst; k++) begin
      check_eq("reset_out_valid", k, 32'(ov[k]), 32'd0);
      check_eq("reset_out_data", k, 32'(od[k]), 32'd0);
      check_eq("reset_out_err", k, 32'(oe[k]), 32'd0);
      check_eq("reset_in_ready", k, 32'(ir[k]), 32'd1);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Basic frame, NUM_SRC=2.
    drive(0, 1'b1, 4'b1010, 1'b0, 1'b1);
    drive(0, 1'b1, 4'b0110, 1'b1, 1'b1);
    check_eq("basic_valid", 0, 32'(ov[0]), 32'd1);
    check_eq("basic_data", 0, 32'(od[0]), 32'b1100);
    check_eq("basic_err", 0, 32'(oe[0]), 32'd0);
    drive(0, 1'b0, 4'b0000, 1'b0, 1'b1);
    check_eq("basic_one_cycle", 0, 32'(ov[0]), 32'd0);

    // Back-to-back frames with no gaps.
    bb = '{4'b0001, 4'b0010, 4'b1111, 4'b1000, 4'b0101, 4'b0101};
    for (int i = 0; i < 6; i++) begin
      check_eq("b2b_in_ready", 0, 32'(ir[0]), 32'd1);
      drive(0, 1'b1, bb[i], 1'(i % 2), 1'b1);
      if (i % 2 == 1) begin
        check_eq("b2b_data", 0, 32'(od[0]), 32'(bb[i-1] ^ bb[i]));
        check_eq("b2b_err", 0, 32'(oe[0]), 32'd0);
      end
    end
    drive(0, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Backpressure, then simultaneous output handshake and input accept.
    drive(0, 1'b1, 4'b0001, 1'b0, 1'b0);
    drive(0, 1'b1, 4'b0010, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_in_ready", 0, 32'(ir[0]), 32'd0);
      check_eq("bp_hold_data", 0, 32'(od[0]), 32'b0011);
      drive(0, 1'b1, 4'($urandom), 1'($urandom), 1'b0);
    end
    drive(0, 1'b1, 4'b1000, 1'b0, 1'b1);
    check_eq("bp_release_valid", 0, 32'(ov[0]), 32'd0);
    drive(0, 1'b1, 4'b0100, 1'b1, 1'b1);
    check_eq("bp_carry_data", 0, 32'(od[0]), 32'b1100);

    // Alignment errors, NUM_SRC=3.
    drive(1, 1'b1, 4'b1100, 1'b0, 1'b1);
    drive(1, 1'b1, 4'b0011, 1'b1, 1'b1);
    check_eq("early_last_data", 1, 32'(od[1]), 32'b1111);
    check_eq("early_last_err", 1, 32'(oe[1]), 32'd1);
    drive(1, 1'b1, 4'b0001, 1'b0, 1'b1);
    drive(1, 1'b1, 4'b0010, 1'b0, 1'b1);
    drive(1, 1'b1, 4'b0100, 1'b0, 1'b1);
    check_eq("no_last_data", 1, 32'(od[1]), 32'b0111);
    check_eq("no_last_err", 1, 32'(oe[1]), 32'd1);
    drive(1, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset mid-frame.
    drive(0, 1'b1, 4'b1001, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 0, 32'(ov[0]), 32'd0);
    check_eq("async_rst_data", 0, 32'(od[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 4'b0011, 1'b0, 1'b1);
    drive(0, 1'b1, 4'b0101, 1'b1, 1'b1);
    check_eq("post_rst_data", 0, 32'(od[0]), 32'b0110);
    check_eq("post_rst_err", 0, 32'(oe[0]), 32'd0);

    // NUM_SRC=1: each beat is its own frame.
    drive(2, 1'b1, 4'b1010, 1'b1, 1'b1);
    check_eq("n1_data0", 2, 32'(od[2]), 32'b1010);
    check_eq("n1_err0", 2, 32'(oe[2]), 32'd0);
    drive(2, 1'b1, 4'b0111, 1'b0, 1'b1);
    check_eq("n1_valid1", 2, 32'(ov[2]), 32'd1);
    check_eq("n1_data1", 2, 32'(od[2]), 32'b0111);
    check_eq("n1_err1", 2, 32'(oe[2]), 32'd1);
    drive(2, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Random soak on all instances at once; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NumInst; k++) begin
        iv[k]   = 1'($urandom_range(0, 1));
        id[k]   = 4'($urandom);
        il[k]   = ($urandom_range(0, 3) == 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csnc_xor_combiner.md
Name: csnc_xor_combiner

Overview:
- Downstream stage of the per-source cyclic shifters in the CSNC encoder.
- Each shifter produces one rotated source word per beat. This block XOR-accumulates NUM_SRC consecutive rotated words into one coded word.
- Emits the coded word over a valid/ready handshake to the packet assembler.
- Checks frame alignment against an in_last marker.

Parameters:
- WIDTH, 4, data word width (L-1), matches shifter width.
- NUM_SRC, 2, rotated words combined per coded word; legal range 1..255.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  rotated word present on in_data.
- in_ready  output  1  combiner accepts a beat this cycle.
- in_data  input  WIDTH  rotated source word from the shifter.
- in_last  input  1  marks the final source word of the current frame.
- out_valid  output  1  coded word available.
- out_ready  input  1  downstream accepts the coded word.
- out_data  output  WIDTH  XOR of all words in the frame.
- out_err  output  1  frame alignment error, qualified by out_valid.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_err=0, accumulator=0, beat counter=0.
  - in_ready is combinational and reads 1 immediately after reset.
  - Reset mid-frame discards the partial accumulation; no output is produced for it.
- Handshakes:
  - An input beat is accepted when in_valid & in_ready.
  - An output beat completes when out_valid & out_ready.
  - in_ready = !out_valid | out_ready, so the block is full-throughput with a one-word output register.
- Accumulation:
  - acc_next = acc ^ in_data on each accepted beat. The first beat of a frame loads in_data directly (acc treated as 0).
  - cnt is $clog2(NUM_SRC+1) bits and counts accepted beats in the current frame.
- Frame close: a frame closes on the accepted beat where cnt==NUM_SRC-1 or in_last==1, whichever comes first. On close, in the same cycle:
  - out_data <= acc ^ in_data;
  - out_valid <= 1;
  - out_err <= (in_last != (cnt==NUM_SRC-1));
  - acc <= 0, cnt <= 0.
- Error cases:
  - in_last early (cnt<NUM_SRC-1): frame closed short, out_err=1.
  - NUM_SRC reached without in_last: frame closed, out_err=1.
- Latency: coded word visible one cycle after the closing beat is accepted.
- Output hold:
  - While out_valid=1 and out_ready=0: out_data and out_err are stable and in_ready=0.
  - Input data changes have no effect while in_ready=0.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle: the output register is freed, and the incoming beat is accumulated into the next frame.
  - If that incoming beat also closes a frame (NUM_SRC=1 or in_last on first beat), out_valid stays 1 with new data.
  - Otherwise out_valid falls to 0.
- NUM_SRC=1: every accepted beat is its own frame. out_data = in_data; out_err = !in_last.
- out_valid never deasserts without a completed output handshake, except on reset.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready -> in_ready.

Test Plan:
- WIDTH=4, NUM_SRC=2: beats 4'b1010 then 4'b0110 with in_last on the second, out_ready=1 -> one cycle after the second beat, out_valid=1, out_data=4'b1100, out_err=0. The output holds for exactly one cycle.
- Back-to-back frames with out_ready held 1: frames (0001,0010), (1111,1000), (0101,0101) streamed with no gaps -> in_ready stays 1 throughout. Outputs 0011, 0111, 0000 appear on consecutive frame boundaries, out_err=0.
- Backpressure: out_ready=0 after the first frame (0001,0010) completes -> out_data=0011 held stable and in_ready=0 for 5 cycles.
  - Raise out_ready in the same cycle as in_valid presents 1000 -> output handshake and input accept both occur.
  - out_valid drops the next cycle; the next frame starts with acc=1000.
- Alignment errors, NUM_SRC=3:
  - in_last on the second beat (1100,0011) -> out_data=1111, out_err=1.
  - Three beats (0001,0010,0100) without in_last -> out_data=0111, out_err=1.
- Reset mid-frame: accept 1 beat of 1001, assert rst_n=0 asynchronously between clock edges -> out_valid=0 and out_data=0 immediately.
  - After release, beats (0011,0101, last) -> out_data=0110; no trace of 1001.
- NUM_SRC=1: stream 1010 (last), 0111 (no last) with out_ready=1 -> outputs 1010 with out_err=0, then 0111 with out_err=1, on consecutive cycles.
